// File: rtl/board_scan_driver.sv
// ============================================================================
// Module   : board_scan_driver
// Brief    : Row-scans a per-frame snapshot of the 16x16 game board onto the LED matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_scan_driver #(
  parameter int DWELL_CYCLES = 2048,
  parameter int BLANK_CYCLES = 64
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Hold,
  input  logic [15:0][15:0] Board,
  output logic [15:0]       RowSink,
  output logic [15:0]       ColDrive,
  output logic [3:0]        CurRow,
  output logic              FrameDone
);

  localparam int c_MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int c_CW         = $clog2(c_MAX_CYCLES) + 1;

  localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);
  localparam logic [c_CW-1:0] c_DWELL_LAST = c_CW'(DWELL_CYCLES - 1);
  localparam logic [15:0]     c_DARK       = 16'hFFFF;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_BLANK = 2'd2;
  localparam logic [1:0] c_DRIVE = 2'd3;

  logic [1:0]        r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [3:0]        r_row;
  logic [15:0]       r_sink;
  logic [15:0]       r_col;
  logic              r_done;
  logic [15:0][15:0] r_shadow;

  logic [1:0]        w_state_nxt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic [3:0]        w_row_nxt;
  logic [15:0]       w_sink_nxt;
  logic [15:0]       w_col_nxt;
  logic              w_done_nxt;
  logic              w_load;

  // Outputs are computed one cycle ahead so they register in lockstep with the state.
  // Every path out of DRIVE passes through a dark cycle, which keeps row changes break-before-make.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_sink_nxt  = r_sink;
    w_col_nxt   = r_col;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;

    if ((r_state != c_IDLE) && !Enable) begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
      w_row_nxt   = 4'd0;
      w_sink_nxt  = c_DARK;
      w_col_nxt   = 16'h0000;
    end else begin
      case (r_state)
        c_IDLE: begin
          w_cnt_nxt  = '0;
          w_row_nxt  = 4'd0;
          w_sink_nxt = c_DARK;
          w_col_nxt  = 16'h0000;
          if (Enable) begin
            w_state_nxt = c_LOAD;
          end
        end

        c_LOAD: begin
          w_load      = !Hold;
          w_row_nxt   = 4'd0;
          w_cnt_nxt   = '0;
          w_sink_nxt  = c_DARK;
          w_col_nxt   = 16'h0000;
          w_state_nxt = c_BLANK;
        end

        c_BLANK: begin
          if (r_cnt == c_BLANK_LAST) begin
            w_state_nxt = c_DRIVE;
            w_cnt_nxt   = '0;
            w_sink_nxt  = ~(16'h0001 << r_row);
            w_col_nxt   = r_shadow[r_row];
          end else begin
            w_cnt_nxt = r_cnt + c_CW'(1);
          end
        end

        c_DRIVE: begin
          if (r_cnt == c_DWELL_LAST) begin
            w_cnt_nxt  = '0;
            w_sink_nxt = c_DARK;
            w_col_nxt  = 16'h0000;
            if (r_row == 4'd15) begin
              w_state_nxt = c_LOAD;
              w_done_nxt  = 1'b1;
            end else begin
              w_row_nxt   = r_row + 4'd1;
              w_state_nxt = c_BLANK;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CW'(1);
          end
        end

        default: begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
          w_row_nxt   = 4'd0;
          w_sink_nxt  = c_DARK;
          w_col_nxt   = 16'h0000;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_row    <= 4'd0;
      r_sink   <= c_DARK;
      r_col    <= 16'h0000;
      r_done   <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_sink  <= w_sink_nxt;
      r_col   <= w_col_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_shadow <= Board;
      end
    end
  end

  assign RowSink   = r_sink;
  assign ColDrive  = r_col;
  assign CurRow    = r_row;
  assign FrameDone = r_done;

endmodule

`default_nettype wire

// File: tb/tb_board_scan_driver.sv
// ============================================================================
// Module   : tb_board_scan_driver
// Brief    : Scoreboard bench for board_scan_driver with short dwell/blank settings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_scan_driver;

  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int PERIOD = 1 + 16 * (BL + DW);

  localparam int K_ZERO = 0;
  localparam int K_IDENT = 1;
  localparam int K_ONES = 2;
  localparam int K_P1 = 3;
  localparam int K_P2 = 4;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Enable;
  logic              Hold;
  logic [15:0][15:0] Board;
  logic [15:0]       RowSink;
  logic [15:0]       ColDrive;
  logic [3:0]        CurRow;
  logic              FrameDone;

  board_scan_driver #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .Hold     (Hold),
    .Board    (Board),
    .RowSink  (RowSink),
    .ColDrive (ColDrive),
    .CurRow   (CurRow),
    .FrameDone(FrameDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          row;
    logic [15:0] cols;
    int          dwell;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] rowval(input int kind, input int i);
    logic [15:0] v;
    logic [3:0]  n;
    n = 4'(i);
    case (kind)
      K_IDENT: v = 16'h0001 << i;
      K_ONES:  v = 16'hFFFF;
      K_P1:    v = {n, ~n, 4'(i + 3), 4'(i * 5)};
      K_P2:    v = {4'(15 - i), n, 4'hA, ~n};
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  task automatic set_board(input int kind);
    for (int i = 0; i < 16; i++) Board[i] = rowval(kind, i);
  endtask

  task automatic push_frame(input int kind, input int nrows, input int last_dwell);
    exp_t e;
    for (int i = 0; i < nrows; i++) begin
      e.row   = i;
      e.cols  = rowval(kind, i);
      e.dwell = (i == nrows - 1) ? last_dwell : DW;
      q.push_back(e);
    end
  endtask

  task automatic wait_row_start(input int r);
    logic [15:0] last;
    logic [15:0] tgt;
    tgt  = ~(16'h0001 << r);
    last = RowSink;
    for (int k = 0; k < 400; k++) begin
      @(negedge Clock);
      if (RowSink == tgt && last != tgt) return;
      last = RowSink;
    end
    chk("wait_row_timeout", 32'(r), 32'hFFFF_FFFF);
  endtask

  task automatic wait_framedone();
    for (int k = 0; k < 400; k++) begin
      @(negedge Clock);
      if (FrameDone) return;
    end
    chk("wait_framedone_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops the scoreboard at every row activation and polices the invariants each cycle.
  logic [15:0] prev_rs = 16'hFFFF;
  bit          in_run = 1'b0;
  exp_t        cur;
  int          run_len = 0;
  int          cyc = 0;
  int          last_fd = 0;
  bit          have_last = 1'b0;

  always @(negedge Clock) begin
    logic [15:0] exp_rs;
    cyc++;
    if (Reset || !Enable) have_last = 1'b0;
    chk("rowsink_one_low", 32'($countones(~RowSink) <= 1), 32'd1);
    if (prev_rs != 16'hFFFF && RowSink != 16'hFFFF && RowSink != prev_rs)
      chk("break_before_make", RowSink, 16'hFFFF);
    if (RowSink == 16'hFFFF) begin
      chk("dark_cols", ColDrive, 16'h0000);
      if (in_run) begin
        chk("dwell_len", run_len, cur.dwell);
        in_run = 1'b0;
      end
    end else if (RowSink != prev_rs) begin
      if (in_run) chk("dwell_len", run_len, cur.dwell);
      if (q.size() == 0) begin
        chk("unexpected_row", RowSink, 16'hFFFF);
        in_run = 1'b0;
      end else begin
        cur    = q.pop_front();
        exp_rs = ~(16'h0001 << cur.row);
        chk("row_sink", RowSink, exp_rs);
        chk("cur_row", CurRow, cur.row);
        chk("col_drive", ColDrive, cur.cols);
        run_len = 1;
        in_run  = 1'b1;
      end
    end else begin
      run_len++;
      if (in_run) chk("col_hold", ColDrive, cur.cols);
    end
    if (FrameDone) begin
      fd_count++;
      chk("fd_after_row15", prev_rs, 16'h7FFF);
      if (have_last) chk("frame_period", cyc - last_fd, PERIOD);
      have_last = 1'b1;
      last_fd   = cyc;
    end
    prev_rs = RowSink;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    Enable = 1'b0;
    Hold   = 1'b0;
    set_board(K_ZERO);
    repeat (2) @(negedge Clock);
    chk("reset_rowsink", RowSink, 16'hFFFF);
    chk("reset_coldrive", ColDrive, 16'h0000);
    chk("reset_currow", CurRow, 4'd0);
    chk("reset_framedone", FrameDone, 1'b0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("idle_dark", RowSink, 16'hFFFF);

    // Frame A identity; board goes all-ones during row 7 so frame B is all ones.
    set_board(K_IDENT);
    push_frame(K_IDENT, 16, DW);
    Enable = 1'b1;
    wait_row_start(7);
    set_board(K_ONES);
    push_frame(K_ONES, 16, DW);

    // Frame C back to identity, then Hold keeps identity through frame D.
    wait_row_start(7);
    set_board(K_IDENT);
    push_frame(K_IDENT, 16, DW);
    wait_row_start(7);
    Hold = 1'b1;
    set_board(K_ZERO);
    push_frame(K_IDENT, 16, DW);
    wait_row_start(7);
    Hold = 1'b0;
    push_frame(K_ZERO, 6, 1);

    // Frame E: drop Enable on the first DRIVE cycle of row 5.
    wait_row_start(5);
    Enable = 1'b0;
    @(negedge Clock);
    chk("disable_rowsink", RowSink, 16'hFFFF);
    chk("disable_coldrive", ColDrive, 16'h0000);
    chk("disable_currow", CurRow, 4'd0);
    chk("disable_framedone", FrameDone, 1'b0);
    repeat (2) @(negedge Clock);

    // Re-enable: LOAD, two BLANK cycles, then row 0 DRIVE.
    set_board(K_P1);
    push_frame(K_P1, 3, 1);
    Enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clock);
      chk("reenable_dark", RowSink, 16'hFFFF);
      chk("reenable_currow", CurRow, 4'd0);
      if (k == 1) chk("reenable_no_fd", FrameDone, 1'b0);
    end
    @(negedge Clock);
    chk("reenable_row0", RowSink, 16'hFFFE);

    // Asynchronous reset between edges during row 2 DRIVE.
    wait_row_start(2);
    #1 Reset = 1'b1;
    #1;
    chk("async_rowsink", RowSink, 16'hFFFF);
    chk("async_coldrive", ColDrive, 16'h0000);
    chk("async_currow", CurRow, 4'd0);
    set_board(K_P2);
    push_frame(K_P2, 16, DW);
    push_frame(K_P2, 1, 1);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Second reset with Hold=1: the first frame must show the cleared shadow.
    wait_framedone();
    wait_row_start(0);
    #1 Reset = 1'b1;
    Hold = 1'b1;
    push_frame(K_ZERO, 16, DW);
    push_frame(K_P2, 16, DW);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    wait_row_start(7);
    Hold = 1'b0;
    wait_framedone();
    wait_framedone();
    Enable = 1'b0;

    for (int k = 0; k < 200 && (q.size() != 0 || in_run); k++) @(negedge Clock);
    repeat (4) @(negedge Clock);
    chk("scoreboard_empty", q.size(), 0);
    chk("framedone_count", fd_count, 7);
    chk("parked_dark", RowSink, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
